// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I opcode constants, immediate formats and the decode-to-execute bundle
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_write;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
  } ex_bundle_t;

  function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: imm_type_of = IMM_I;
      OPC_STORE:                     imm_type_of = IMM_S;
      OPC_BRANCH:                    imm_type_of = IMM_B;
      OPC_LUI, OPC_AUIPC:            imm_type_of = IMM_U;
      OPC_JAL:                       imm_type_of = IMM_J;
      default:                       imm_type_of = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational sign-extended immediate extraction for RV32I formats
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  imm_type_t kind;
  assign kind = imm_type_of(instr_i[6:0]);

  always_comb begin
    imm_o = '0;
    case (kind)
      IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm_o = {instr_i[31:12], 12'b0};
      IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - RV32I decode stage with RAW scoreboard and execute handshake
module instr_decode_stage
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  input  logic [31:0] Read_data1,
  input  logic [31:0] Read_data2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5
);

  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        ex_valid_q, ex_valid_d;
  ex_bundle_t  ex_q, ex_d;
  logic [31:0] pending_q, pending_d;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        uses_rs1, uses_rs2, writes_rd, hazard, issue;

  assign opcode = id_instr_q[6:0];
  assign rd     = id_instr_q[11:7];
  assign rs1    = id_instr_q[19:15];
  assign rs2    = id_instr_q[24:20];

  imm_gen u_imm_gen (
    .instr_i (id_instr_q),
    .imm_o   (imm)
  );

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
    if (rd == 5'd0) writes_rd = 1'b0;
  end

  assign hazard = (uses_rs1 && (rs1 != 5'd0) && pending_q[rs1]) ||
                  (uses_rs2 && (rs2 != 5'd0) && pending_q[rs2]);
  assign issue    = id_valid_q && !hazard && !flush && (!ex_valid_q || ex_ready);
  assign if_ready = !flush && (!id_valid_q || issue);

  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (if_valid && if_ready) begin
      id_valid_d = 1'b1;
      id_instr_d = if_instr;
      id_pc_d    = if_pc;
    end else if (issue) begin
      id_valid_d = 1'b0;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (issue) begin
      ex_valid_d       = 1'b1;
      ex_d.pc          = id_pc_q;
      ex_d.rs1_data    = Read_data1;
      ex_d.rs2_data    = Read_data2;
      ex_d.imm         = imm;
      ex_d.rd          = rd;
      ex_d.reg_write   = writes_rd;
      ex_d.opcode      = opcode;
      ex_d.funct3      = id_instr_q[14:12];
      ex_d.funct7b5    = id_instr_q[30];
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // Set is applied after clear so a newly issued writer keeps its pending bit.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid && (wb_rd != 5'd0)) pending_d[wb_rd] = 1'b0;
    if (issue && writes_rd) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      pending_q  <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
      pending_q  <= pending_d;
    end
  end

  assign Rs1          = rs1;
  assign Rs2          = rs2;
  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7b5  = ex_q.funct7b5;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - scoreboard bench for instr_decode_stage against a field-level reference model
module tb_instr_decode_stage;
  import rv32_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, if_valid, if_ready, flush, wb_valid, ex_valid, ex_ready, ex_reg_write, ex_funct7b5;
  logic [31:0] if_instr, if_pc, Read_data1, Read_data2, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  Rs1, Rs2, wb_rd, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .flush(flush), .Rs1(Rs1), .Rs2(Rs2), .Read_data1(Read_data1),
    .Read_data2(Read_data2), .wb_valid(wb_valid), .wb_rd(wb_rd), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5)
  );

  typedef struct {
    logic [31:0] pc, imm, rs1d, rs2d, wbval;
    logic [4:0]  rd;
    logic        rw, chk1, chk2, f7;
    logic [6:0]  opc;
    logic [2:0]  f3;
  } exp_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  exp_t        expq[$];
  wb_t         wbq[$];
  logic [31:0] rf[32];
  logic [31:0] arch[32];
  int          outstanding[32];
  int          total = 0;
  int          bad = 0;
  logic        wb_hold = 1'b1;
  logic        rand_mode = 1'b0;
  logic [31:0] wb_cur;
  logic [31:0] next_pc = 32'h0000_1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference decode: immediates rebuilt as signed integer offsets from the fields.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int v;
    logic [6:0] op;
    op = ins[6:0];
    e.pc = pc; e.opc = op; e.f3 = ins[14:12]; e.f7 = ins[30]; e.rd = ins[11:7];
    e.chk1 = op inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
    e.chk2 = op inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    e.rw = (op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP}) && (e.rd != 5'd0);
    case (op)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        v = int'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      OPC_STORE: begin
        v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      OPC_BRANCH: begin
        v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      OPC_LUI, OPC_AUIPC: v = int'(ins[31:12]) * 4096;
      OPC_JAL: begin
        v = int'(ins[31]) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    e.imm = 32'(v);
    e.rs1d = '0; e.rs2d = '0; e.wbval = '0;
    return e;
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int rd);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, 5'(rs1), 3'b000, 5'(rd), OPC_OPIMM};
  endfunction

  function automatic logic [31:0] enc_r(input int rs2, input int rs1, input int rd);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), OPC_OP};
  endfunction

  function automatic logic [31:0] enc_s(input int rs2, input int rs1);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b010, 5'b0, OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1);
    logic [12:0] b;
    b = 13'(off);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'b000, b[4:1], b[11], OPC_BRANCH};
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic fetch(input logic [31:0] ins);
    exp_t e;
    int   waited = 0;
    if_instr = ins; if_pc = next_pc; if_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (if_ready) break;
      waited++;
      if (waited > 500) begin
        total++; bad++;
        $display("FAIL fetch_timeout: actual if_ready=0 for %0d cycles required=accept", waited);
        break;
      end
    end
    if (if_ready) begin
      e = model(ins, next_pc);
      e.rs1d = arch[ins[19:15]];
      e.rs2d = arch[ins[24:20]];
      e.wbval = $urandom;
      if (e.rw) begin
        arch[e.rd] = e.wbval;
        outstanding[e.rd]++;
      end
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    if_valid = 1'b0;
    next_pc += 32'd4;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((expq.size() != 0 || wbq.size() != 0 || wb_valid) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      total++; bad++;
      $display("FAIL drain_timeout: actual outstanding=%0d required=0", expq.size() + wbq.size());
    end
  endtask

  always @(negedge clk) begin
    Read_data1 = rf[Rs1];
    Read_data2 = rf[Rs2];
  end

  initial begin
    wb_t w;
    wb_valid = 1'b0; wb_rd = '0; wb_cur = '0;
    forever begin
      @(posedge clk);
      if (wb_valid) begin
        rf[wb_rd] = wb_cur;
        outstanding[wb_rd]--;
      end
      #1;
      wb_valid = 1'b0;
      if (!wb_hold && wbq.size() > 0 && $urandom_range(0, 2) != 0) begin
        w = wbq.pop_front();
        wb_rd = w.rd; wb_cur = w.val; wb_valid = 1'b1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) ex_ready = ($urandom_range(0, 3) != 0);
  end

  exp_t        mon_e;
  wb_t         mon_w;
  logic        stall_seen = 1'b0;
  logic [31:0] snap_pc, snap_d1, snap_d2, snap_imm;
  logic [4:0]  snap_rd;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_seen) begin
        check("hold_valid", 32'(ex_valid), 32'd1);
        check("hold_pc", ex_pc, snap_pc);
        check("hold_rs1_data", ex_rs1_data, snap_d1);
        check("hold_rs2_data", ex_rs2_data, snap_d2);
        check("hold_imm", ex_imm, snap_imm);
        check("hold_rd", 32'(ex_rd), 32'(snap_rd));
      end
      stall_seen = ex_valid && !ex_ready;
      snap_pc = ex_pc; snap_d1 = ex_rs1_data; snap_d2 = ex_rs2_data; snap_imm = ex_imm; snap_rd = ex_rd;
      if (ex_valid && ex_ready) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_issue: actual pc=%h required=no transfer", ex_pc);
        end else begin
          mon_e = expq.pop_front();
          check("ex_pc", ex_pc, mon_e.pc);
          check("ex_imm", ex_imm, mon_e.imm);
          check("ex_rd", 32'(ex_rd), 32'(mon_e.rd));
          check("ex_reg_write", 32'(ex_reg_write), 32'(mon_e.rw));
          check("ex_opcode", 32'(ex_opcode), 32'(mon_e.opc));
          check("ex_funct3", 32'(ex_funct3), 32'(mon_e.f3));
          check("ex_funct7b5", 32'(ex_funct7b5), 32'(mon_e.f7));
          if (mon_e.chk1) check("ex_rs1_data", ex_rs1_data, mon_e.rs1d);
          if (mon_e.chk2) check("ex_rs2_data", ex_rs2_data, mon_e.rs2d);
          if (mon_e.rw) begin
            mon_w.rd = mon_e.rd; mon_w.val = mon_e.wbval;
            wbq.push_back(mon_w);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] ins, pc_a;
    logic [6:0]  ops[10];
    exp_t        pe;
    wb_t         w;
    ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, 7'b0001111};
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b1;
    Read_data1 = '0; Read_data2 = '0;
    for (int r = 0; r < 32; r++) begin
      rf[r] = (r == 0) ? 32'd0 : $urandom;
      arch[r] = rf[r];
      outstanding[r] = 0;
    end
    rf[1] = 32'd10; arch[1] = 32'd10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_if_ready", 32'(if_ready), 32'd1);
    check("reset_rs1", 32'(Rs1), 32'd0);
    check("reset_rs2", 32'(Rs2), 32'd0);
    check("reset_ex_pc", ex_pc, 32'd0);
    check("reset_ex_imm", ex_imm, 32'd0);
    check("reset_pending", dut.pending_q, 32'd0);
    align();
    rst_n = 1'b1;

    // addi x5,x1,3 with x1 = 10
    align();
    fetch(enc_i(3, 1, 5));
    @(negedge clk);
    check("addi_latency_early", 32'(ex_valid), 32'd0);
    @(negedge clk);
    check("addi_valid", 32'(ex_valid), 32'd1);
    check("addi_rs1_data", ex_rs1_data, 32'd10);
    check("addi_imm", ex_imm, 32'd3);
    check("addi_rd", 32'(ex_rd), 32'd5);
    check("addi_pending5", 32'(dut.pending_q[5]), 32'd1);

    // add x6,x5,x2 stalls until x5 retires
    align();
    fetch(enc_r(2, 5, 6));
    repeat (3) @(negedge clk);
    check("raw_if_ready", 32'(if_ready), 32'd0);
    check("raw_no_issue", 32'(ex_valid), 32'd0);
    wb_hold = 1'b0;
    drain(200);

    // x0 as destination and source
    align();
    fetch(enc_i(1, 0, 0));
    fetch(enc_r(0, 0, 7));
    @(negedge clk);
    @(negedge clk);
    check("x0_second_issued", 32'(ex_rd), 32'd7);
    check("x0_pending0", 32'(dut.pending_q[0]), 32'd0);
    drain(200);

    // backpressure: two instructions, execute stalled three cycles
    align();
    ex_ready = 1'b0;
    fetch(enc_i(5, 1, 3));
    fetch(enc_i(6, 2, 4));
    repeat (3) begin
      @(negedge clk);
      check("bp_if_ready", 32'(if_ready), 32'd0);
    end
    align();
    ex_ready = 1'b1;
    drain(200);

    // writeback of x5 in the same cycle a new x5 writer issues
    align();
    wb_hold = 1'b1;
    fetch(enc_i(1, 0, 5));
    repeat (3) @(negedge clk);
    align();
    fetch(enc_i(7, 0, 5));
    #2;
    if (wbq.size() == 0) begin
      total++; bad++;
      $display("FAIL simul_wb_missing: actual queued=0 required=1");
    end else begin
      w = wbq.pop_front();
      wb_rd = w.rd; wb_cur = w.val; wb_valid = 1'b1;
    end
    @(negedge clk);
    check("simul_pending5", 32'(dut.pending_q[5]), 32'd1);
    check("simul_issued_rd", 32'(ex_rd), 32'd5);
    wb_hold = 1'b0;
    drain(200);

    // beq x1,x2,-4
    align();
    fetch(enc_b(-4, 2, 1));
    @(negedge clk);
    @(negedge clk);
    check("beq_valid", 32'(ex_valid), 32'd1);
    check("beq_imm", ex_imm, 32'hFFFF_FFFC);
    drain(200);

    // flush a store stalled on x8
    align();
    wb_hold = 1'b1;
    pc_a = next_pc;
    fetch(enc_i(1, 0, 8));
    fetch(enc_s(8, 8));
    repeat (2) @(negedge clk);
    check("flush_pre_stall", 32'(if_ready), 32'd0);
    align();
    flush = 1'b1;
    align();
    flush = 1'b0;
    pe = expq.pop_back();
    check("flush_dropped_pc", pe.pc, pc_a + 32'd4);
    @(negedge clk);
    check("flush_id_valid", 32'(dut.id_valid_q), 32'd0);
    check("flush_ex_pc", ex_pc, pc_a);
    check("flush_pending", dut.pending_q, 32'h0000_0100);
    check("flush_if_ready", 32'(if_ready), 32'd1);
    wb_hold = 1'b0;
    drain(200);

    // randomized stream over x0..x7
    rand_mode = 1'b1;
    align();
    for (int k = 0; k < 400; k++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      pe = model(ins, 32'd0);
      if (pe.rw && outstanding[pe.rd] > 0) ins[11:7] = 5'd0;
      fetch(ins);
      if ($urandom_range(0, 3) == 0) align();
    end
    rand_mode = 1'b0;
    align();
    ex_ready = 1'b1;
    drain(5000);
    check("final_pending_clear", dut.pending_q, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Decode stage between instruction fetch and execute in the pipelined RV32I core. Holds one fetched instruction, drives the register-file read addresses, captures the operands the register file returns, generates the immediate, and hands a decoded bundle to execute over a valid/ready handshake. A 32-entry scoreboard tracks registers with writes in flight and stalls issue on read-after-write hazards until writeback clears them.

## Interface
- No parameters. XLEN fixed at 32; 32 architectural registers.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_valid / if_ready  in / out  1 / 1  fetch handshake.
- if_instr / if_pc  in  32 / 32  fetched instruction and its PC.
- flush  in  1  kill the instruction held in decode (branch redirect).
- Rs1 / Rs2  out  5 / 5  register-file read addresses, decoded from the held instruction.
- Read_data1 / Read_data2  in  32 / 32  register-file read data; valid from the falling edge after Rs1/Rs2 settle.
- wb_valid / wb_rd  in  1 / 5  writeback retiring a write to wb_rd; clears the scoreboard.
- ex_valid / ex_ready  out / in  1 / 1  execute handshake.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  32 each.
- ex_rd  out  5; ex_reg_write  out  1; ex_opcode  out  7; ex_funct3  out  3; ex_funct7b5  out  1.

## Operation
- ID register (id_valid, id_instr, id_pc) loads on the if_valid & if_ready handshake. if_ready = !flush & (!id_valid | issue).
- Rs1 = id_instr[19:15] and Rs2 = id_instr[24:20], always, regardless of whether the source is used.
- Source usage: rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP. rs2 is used by BRANCH, STORE and OP.
- Write-back flag: writes_rd is set for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, and only when rd != 0.
- Hazard: raised when a source that is used and non-zero has pending[src] = 1.
- Issue: issue = id_valid & !hazard & !flush & (!ex_valid | ex_ready).
- On issue, the EX register loads Read_data1/2, the immediate, the PC, the decoded fields and ex_reg_write = writes_rd; ex_valid is set.
- When ex_valid & ex_ready occur without a new issue, ex_valid clears.
- Scoreboard:
  - Issue with writes_rd sets pending[rd].
  - wb_valid with wb_rd != 0 clears pending[wb_rd].
  - If both target the same register in the same cycle, the set wins (a new writer is in flight).
  - pending[0] is constant 0.
- Immediate by opcode: I (LOAD, OP-IMM, JALR), S, B, U and J formats, each sign-extended to 32 bits. All other opcodes produce imm = 0.
- Unknown opcodes issue with ex_reg_write = 0 and no scoreboard effect. Execute raises any illegal-instruction trap.
- flush clears id_valid on the next edge and blocks both issue and load that cycle.
  - flush does not touch the EX register or the scoreboard. Writes already issued retire through writeback as normal.

## Timing
- Reset (asynchronous assert, synchronous release): id_valid = 0, ex_valid = 0, pending = 0.
- Reset values of outputs: all ex_* data = 0, Rs1 = Rs2 = 0, if_ready = 1.
- Latency: instruction accepted at edge N; read addresses valid after N; register file samples at the falling edge in cycle N; issue at edge N+1 if there is no hazard and no backpressure. Throughput is one instruction per cycle.
- Scoreboard is registered, so a wb clear at edge N unblocks issue at edge N+1. By then the register file has committed the write at N and re-read it at the following falling edge, so the captured operand is the new value.
- Backpressure: with ex_valid & !ex_ready, the EX register holds stable and decode holds. ex_* must not change while ex_valid & !ex_ready.
- Reset mid-stall drops every in-flight instruction and clears all pending bits.

## Structure
- Shared package rv32_pkg holds:
  - opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP);
  - imm_type_t enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
- Sub-module imm_gen: combinational instr -> imm. The scoreboard stays inline.

## Test plan
- Issue without hazard: addi x5,x1,3 with x1 = 10 -> ex_valid one cycle after accept, ex_rs1_data = 10, ex_imm = 3, ex_rd = 5, pending[5] = 1.
- RAW stall: addi x5,... then add x6,x5,x2 -> the second instruction stalls and if_ready = 0. wb_valid with wb_rd = 5 -> issue on the following edge with the written value.
- x0 handling: addi x0,x0,1 then add x7,x0,x0 -> ex_reg_write = 0, pending stays 0, no stall.
- Backpressure: hold ex_ready = 0 for 3 cycles -> ex_* stable, if_ready = 0. Release -> one transfer per cycle, nothing lost.
- Simultaneous set/clear: wb_rd = 5 while an instruction writing x5 issues -> pending[5] remains 1.
- Immediate and flush:
  - beq with offset -4 -> ex_imm = 0xFFFFFFFC.
  - flush while stalled -> id_valid = 0 next cycle, ex_* unchanged, pending unchanged.
